sa_ar_channel: RTL and testbench

- Read-address half of the slave-side arbiter; it pairs with the read-data return path of the same slave port.
- Round-robin arbitrates AR requests from MST_AMT dispatchers and prefixes the master index onto ARID.
- Splits INCR bursts that cross a 4 KB boundary into two slave bursts.
- Pushes {crossing flag, slave ID} per issued burst to the R-channel RLAST filter, and honours that filter's full/stall signal.

---
 rtl/sa_ar_channel.sv | 186 ++++++++++++++++++
 tb/tb_sa_ar_channel.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ar_channel.sv
// sa_ar_channel: read-address half of a slave-side arbiter.
// Round-robin arbitrates dispatcher AR requests and prefixes the master index onto ARID.
// INCR bursts that cross a 4 KB page are split into two slave bursts.
// Each issued burst is reported to the RLAST filter FIFO, and the filter's full flag stalls issue.
// Ports:
//   ACLK_i, ARESETn_i            clock, async active-low reset
//   dsp_AR*_i / dsp_ARREADY_o    per-master AR channels, master k at slice k
//   s_AR*_o / s_ARREADY_i        slave AR channel
//   AR_AxID_o, AR_crossing_flag_o, AR_shift_en_o, AR_stall_i   RLAST filter FIFO interface
module sa_ar_channel #(
  parameter int MST_AMT        = 3,
  parameter int MST_ID_W       = $clog2(MST_AMT),
  parameter int ADDR_WIDTH     = 32,
  parameter int TRANS_MST_ID_W = 5,
  parameter int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W,
  parameter int LEN_W          = 8,
  parameter int SIZE_W         = 3
) (
  input  logic                               ACLK_i,
  input  logic                               ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]      dsp_ARADDR_i,
  input  logic [LEN_W*MST_AMT-1:0]           dsp_ARLEN_i,
  input  logic [SIZE_W*MST_AMT-1:0]          dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                 dsp_ARVALID_i,
  output logic [MST_AMT-1:0]                 dsp_ARREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]          s_ARID_o,
  output logic [ADDR_WIDTH-1:0]              s_ARADDR_o,
  output logic [LEN_W-1:0]                   s_ARLEN_o,
  output logic [SIZE_W-1:0]                  s_ARSIZE_o,
  output logic                               s_ARVALID_o,
  input  logic                               s_ARREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]          AR_AxID_o,
  output logic                               AR_crossing_flag_o,
  output logic                               AR_shift_en_o,
  input  logic                               AR_stall_i
);

  localparam int unsigned PAGE_W = ADDR_WIDTH - 12;

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

  typedef struct packed {
    logic [TRANS_SLV_ID_W-1:0] id;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [LEN_W-1:0]          len;
    logic [SIZE_W-1:0]         size;
  } ar_req_t;

  state_t                state_q, state_d;
  logic [MST_ID_W-1:0]   ptr_q;
  logic [MST_ID_W-1:0]   grant_c;
  logic                  grant_vld_c;
  logic                  mst_hs_c;
  logic                  slv_hs_c;

  logic [TRANS_MST_ID_W-1:0] sel_id_c;
  logic [ADDR_WIDTH-1:0]     sel_addr_c;
  logic [LEN_W-1:0]          sel_len_c;
  logic [SIZE_W-1:0]         sel_size_c;

  logic [12:0]           btb_c;
  logic [12:0]           btb_beats_c;
  logic [15:0]           tot_c;
  logic                  cross_c;
  logic [LEN_W-1:0]      len1_c;
  logic [LEN_W-1:0]      len2_c;
  logic [ADDR_WIDTH-1:0] addr2_c;

  ar_req_t               cur_q;
  logic [ADDR_WIDTH-1:0] addr2_q;
  logic [LEN_W-1:0]      len2_q;
  logic                  flag_q;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    int sum;
    logic [MST_ID_W-1:0] idx;
    grant_c     = '0;
    grant_vld_c = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= MST_AMT) sum = sum - MST_AMT;
      idx = MST_ID_W'(sum);
      if (!grant_vld_c && dsp_ARVALID_i[idx]) begin
        grant_c     = idx;
        grant_vld_c = 1'b1;
      end
    end
  end

  // Reset gates the ready so no dispatcher sees acceptance while held in reset.
  assign mst_hs_c = ARESETn_i && (state_q == IDLE) && grant_vld_c;

  always_comb begin
    dsp_ARREADY_o = '0;
    if (mst_hs_c) dsp_ARREADY_o[grant_c] = 1'b1;
  end

  // Mux the granted master's request fields.
  always_comb begin
    sel_id_c   = '0;
    sel_addr_c = '0;
    sel_len_c  = '0;
    sel_size_c = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      if (grant_c == MST_ID_W'(k)) begin
        sel_id_c   = dsp_ARID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr_c = dsp_ARADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len_c  = dsp_ARLEN_i[k*LEN_W +: LEN_W];
        sel_size_c = dsp_ARSIZE_i[k*SIZE_W +: SIZE_W];
      end
    end
  end

  // 4 KB split: bytes left in the page vs. bytes requested.
  always_comb begin
    btb_c       = 13'd4096 - {1'b0, sel_addr_c[11:0]};
    tot_c       = (16'(sel_len_c) + 16'd1) << sel_size_c;
    cross_c     = tot_c > {3'b000, btb_c};
    btb_beats_c = btb_c >> sel_size_c;
    len1_c      = cross_c ? LEN_W'(btb_beats_c - 13'd1) : sel_len_c;
    len2_c      = sel_len_c - len1_c - LEN_W'(1);
    addr2_c     = {sel_addr_c[ADDR_WIDTH-1:12] + PAGE_W'(1), 12'h000};
  end

  assign s_ARVALID_o   = (state_q != IDLE) && !AR_stall_i;
  assign slv_hs_c      = s_ARVALID_o && s_ARREADY_i;
  assign AR_shift_en_o = slv_hs_c;

  // State register and round-robin pointer.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (mst_hs_c) begin
        ptr_q <= (int'(grant_c) == MST_AMT - 1) ? '0 : grant_c + MST_ID_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mst_hs_c) state_d = ISSUE1;
      ISSUE1:  if (slv_hs_c) state_d = flag_q ? ISSUE2 : IDLE;
      ISSUE2:  if (slv_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload registers: first burst loaded on capture, second burst swapped in after the first issues.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      cur_q   <= '0;
      addr2_q <= '0;
      len2_q  <= '0;
      flag_q  <= 1'b0;
    end else if (mst_hs_c) begin
      cur_q.id   <= {grant_c, sel_id_c};
      cur_q.addr <= sel_addr_c;
      cur_q.len  <= len1_c;
      cur_q.size <= sel_size_c;
      addr2_q    <= addr2_c;
      len2_q     <= len2_c;
      flag_q     <= cross_c;
    end else if (slv_hs_c && (state_q == ISSUE1) && flag_q) begin
      cur_q.addr <= addr2_q;
      cur_q.len  <= len2_q;
      flag_q     <= 1'b0;
    end
  end

  assign s_ARID_o           = cur_q.id;
  assign s_ARADDR_o         = cur_q.addr;
  assign s_ARLEN_o          = cur_q.len;
  assign s_ARSIZE_o         = cur_q.size;
  assign AR_AxID_o          = cur_q.id;
  assign AR_crossing_flag_o = flag_q;

endmodule

// File: tb/tb_sa_ar_channel.sv
// Self-checking bench for sa_ar_channel: behavioural page-split/round-robin model plus directed literals.
module tb_sa_ar_channel;

  logic        clk;
  logic        rst_n;
  logic [14:0] arid;
  logic [95:0] araddr;
  logic [23:0] arlen;
  logic [8:0]  arsize;
  logic [2:0]  arvalid;
  logic [2:0]  arready;
  logic [6:0]  s_id;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [2:0]  s_size;
  logic        s_valid;
  logic        s_ready;
  logic [6:0]  f_id;
  logic        f_flag;
  logic        f_shift;
  logic        stall;

  sa_ar_channel dut (
    .ACLK_i             (clk),
    .ARESETn_i          (rst_n),
    .dsp_ARID_i         (arid),
    .dsp_ARADDR_i       (araddr),
    .dsp_ARLEN_i        (arlen),
    .dsp_ARSIZE_i       (arsize),
    .dsp_ARVALID_i      (arvalid),
    .dsp_ARREADY_o      (arready),
    .s_ARID_o           (s_id),
    .s_ARADDR_o         (s_addr),
    .s_ARLEN_o          (s_len),
    .s_ARSIZE_o         (s_size),
    .s_ARVALID_o        (s_valid),
    .s_ARREADY_i        (s_ready),
    .AR_AxID_o          (f_id),
    .AR_crossing_flag_o (f_flag),
    .AR_shift_en_o      (f_shift),
    .AR_stall_i         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        flag;
  } burst_t;

  burst_t exp_q[$];
  int     rr_ptr;
  int     checks;
  int     fails;
  int     shift_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request becomes one burst, or two if its byte span passes the next 4 KB page start.
  function automatic void model_push(input int m, input logic [4:0] id, input logic [31:0] a,
                                     input logic [7:0] len, input logic [2:0] sz);
    longint bytes, page_end, beats1;
    burst_t b;
    bytes    = (longint'(len) + 1) << sz;
    page_end = (longint'(a) | 64'hFFF) + 1;
    b.id     = {2'(m), id};
    b.size   = sz;
    if (longint'(a) + bytes > page_end) begin
      beats1 = (page_end - longint'(a)) >> sz;
      b.addr = a;
      b.len  = 8'(beats1 - 1);
      b.flag = 1'b1;
      exp_q.push_back(b);
      b.addr = 32'(page_end);
      b.len  = 8'(longint'(len) - beats1);
      b.flag = 1'b0;
      exp_q.push_back(b);
    end else begin
      b.addr = a;
      b.len  = len;
      b.flag = 1'b0;
      exp_q.push_back(b);
    end
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0] er;
    logic       ev;
    logic       es;
    int         g;
    if (!rst_n) begin
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_valid", 64'(s_valid), 64'd0);
      chk("rst_shift", 64'(f_shift), 64'd0);
      chk("rst_payload", {s_id, s_addr, s_len, s_size, f_flag}, 64'd0);
      exp_q.delete();
      rr_ptr = 0;
    end else begin
      g  = -1;
      er = 3'b000;
      if (exp_q.size() == 0) begin
        for (int i = 0; i < 3; i++) begin
          if (g < 0 && arvalid[(rr_ptr + i) % 3]) g = (rr_ptr + i) % 3;
        end
      end
      if (g >= 0) er = 3'(1) << g;
      chk("arready", 64'(arready), 64'(er));
      ev = (exp_q.size() != 0) && !stall;
      es = ev && s_ready;
      chk("s_valid", 64'(s_valid), 64'(ev));
      chk("shift_en", 64'(f_shift), 64'(es));
      if (exp_q.size() != 0) begin
        chk("payload", {s_id, s_addr, s_len, s_size, f_flag},
            {exp_q[0].id, exp_q[0].addr, exp_q[0].len, exp_q[0].size, exp_q[0].flag});
        chk("axid", 64'(f_id), 64'(exp_q[0].id));
      end
      if (f_shift) shift_cnt++;
      if (es) void'(exp_q.pop_front());
      if (g >= 0) begin
        model_push(g, arid[g*5 +: 5], araddr[g*32 +: 32], arlen[g*8 +: 8], arsize[g*3 +: 3]);
        rr_ptr = (g + 1) % 3;
      end
    end
  end

  task automatic set_req(input int m, input logic [4:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz);
    arid[m*5 +: 5]    = id;
    araddr[m*32 +: 32] = a;
    arlen[m*8 +: 8]   = len;
    arsize[m*3 +: 3]  = sz;
  endtask

  // Present one request on master m and return once it has been accepted (bounded wait).
  task automatic do_req(input int m, input logic [4:0] id, input logic [31:0] a,
                        input logic [7:0] len, input logic [2:0] sz);
    bit ok;
    @(posedge clk); #1;
    set_req(m, id, a, len, sz);
    arvalid[m] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (arready[m]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    arvalid[m] = 1'b0;
  endtask

  task automatic chk_burst(input string name, input logic [6:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [2:0] sz, input logic flag,
                           input logic v, input logic sh);
    chk({name, "_valid"}, 64'(s_valid), 64'(v));
    chk({name, "_shift"}, 64'(f_shift), 64'(sh));
    chk({name, "_fields"}, {s_id, s_addr, s_len, s_size, f_flag}, {id, a, len, sz, flag});
  endtask

  initial begin
    int         grants[$];
    int         c0;
    bit   [2:0] hs;
    logic [31:0] a;
    logic [2:0]  sz;
    checks = 0; fails = 0; shift_cnt = 0; rr_ptr = 0;
    rst_n = 1'b0; stall = 1'b0; s_ready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arvalid = 3'b000;

    // All masters request from reset: grants rotate 0,1,2,0.
    set_req(0, 5'h01, 32'h0000_0000, 8'd0, 3'd2);
    set_req(1, 5'h02, 32'h0000_1000, 8'd1, 3'd2);
    set_req(2, 5'h04, 32'h0000_2000, 8'd2, 3'd2);
    arvalid = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      case (arready)
        3'b001: grants.push_back(0);
        3'b010: grants.push_back(1);
        3'b100: grants.push_back(2);
        default: ;
      endcase
    end
    @(posedge clk); #1 arvalid = 3'b000;
    repeat (4) @(posedge clk);
    chk("rr_count", 64'(grants.size() >= 4), 64'd1);
    if (grants.size() >= 4) begin
      chk("rr_g0", 64'(grants[0]), 64'd0);
      chk("rr_g1", 64'(grants[1]), 64'd1);
      chk("rr_g2", 64'(grants[2]), 64'd2);
      chk("rr_g3", 64'(grants[3]), 64'd0);
    end

    // Single burst inside a page.
    c0 = shift_cnt;
    do_req(1, 5'h03, 32'h0000_0100, 8'd3, 3'd2);
    @(negedge clk);
    chk_burst("single", 7'h23, 32'h0000_0100, 8'd3, 3'd2, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("single_pulses", 64'(shift_cnt - c0), 64'd1);

    // Split burst across 0x1000.
    c0 = shift_cnt;
    do_req(2, 5'h03, 32'h0000_0FF0, 8'd7, 3'd2);
    @(negedge clk);
    chk_burst("split1", 7'h43, 32'h0000_0FF0, 8'd3, 3'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk_burst("split2", 7'h43, 32'h0000_1000, 8'd3, 3'd2, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("split_pulses", 64'(shift_cnt - c0), 64'd2);

    // Ends exactly on the boundary: not split.
    c0 = shift_cnt;
    do_req(0, 5'h07, 32'h0000_0FE0, 8'd7, 3'd2);
    @(negedge clk);
    chk_burst("edge", 7'h07, 32'h0000_0FE0, 8'd7, 3'd2, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("edge_pulses", 64'(shift_cnt - c0), 64'd1);

    // Filter-full stall for 5 cycles, then slave backpressure for 3.
    stall = 1'b1;
    do_req(0, 5'h1F, 32'h2000_0040, 8'd15, 3'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_burst("stall", 7'h1F, 32'h2000_0040, 8'd15, 3'd3, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_burst("bp", 7'h1F, 32'h2000_0040, 8'd15, 3'd3, 1'b0, 1'b1, 1'b0);
    end
    @(posedge clk); #1 s_ready = 1'b1;
    @(negedge clk);
    chk_burst("release", 7'h1F, 32'h2000_0040, 8'd15, 3'd3, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);

    // Reset during the second half of a split burst.
    do_req(1, 5'h0A, 32'h0000_0FF8, 8'd3, 3'd3);
    @(negedge clk);
    chk_burst("rsplit1", 7'h2A, 32'h0000_0FF8, 8'd0, 3'd3, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(s_valid), 64'd0);
    chk("async_shift", 64'(f_shift), 64'd0);
    chk("async_payload", {s_id, s_addr, s_len, s_size, f_flag}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 5'h11, 32'h0000_3000, 8'd0, 3'd0);
    set_req(2, 5'h12, 32'h0000_4000, 8'd0, 3'd0);
    arvalid = 3'b101;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(arready), 64'b001);
    repeat (6) @(posedge clk);
    #1 arvalid = 3'b000;
    repeat (4) @(posedge clk);

    // Randomized traffic against the model.
    hs = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      stall   = ($urandom_range(0, 4) == 0);
      s_ready = ($urandom_range(0, 3) != 0);
      for (int m = 0; m < 3; m++) begin
        if (!arvalid[m] || hs[m]) begin
          if ($urandom_range(0, 2) != 0) begin
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
            sz = 3'($urandom_range(0, 4));
            a  = a & ~((32'd1 << sz) - 32'd1);
            set_req(m, 5'($urandom), a,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)),
                    sz);
            arvalid[m] = 1'b1;
          end else begin
            arvalid[m] = 1'b0;
          end
        end
      end
      @(negedge clk);
      hs = arvalid & arready;
    end
    @(posedge clk); #1;
    arvalid = 3'b000;
    stall   = 1'b0;
    s_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
